// File: rtl/fridge_cooling_ctrl_if.sv
// Signal bundle between the fridge cooling controller and its environment.
//   i          : power enable (low forces OFF)
//   fgt, frt   : fridge / freezer setpoint codes (higher = warmer)
//   fg_meas    : measured fridge temperature code
//   fr_meas    : measured freezer temperature code
//   door_open  : any compartment door open
//   compressor : compressor run
//   damper     : fridge air damper open
//   fan        : freezer evaporator fan
//   heater     : defrost heater
//   state      : controller state (OFF=0, IDLE=1, COOL=2, HOLD=3, DEFROST=4)
// The slave modport is taken by the controller; master is the driving side.
interface fridge_cooling_ctrl_if;
  logic       i;
  logic [4:0] fgt;
  logic [4:0] frt;
  logic [4:0] fg_meas;
  logic [4:0] fr_meas;
  logic       door_open;
  logic       compressor;
  logic       damper;
  logic       fan;
  logic       heater;
  logic [2:0] state;

  modport master (
    output i, fgt, frt, fg_meas, fr_meas, door_open,
    input  compressor, damper, fan, heater, state
  );

  modport slave (
    input  i, fgt, frt, fg_meas, fr_meas, door_open,
    output compressor, damper, fan, heater, state
  );
endinterface

// File: rtl/fridge_cooling_ctrl.sv
// Cooling-loop controller: drives compressor, fridge damper and freezer fan from the stored
// setpoints and measured compartment temperatures, with hysteresis on the demand flags and
// minimum on/off protection for the compressor. Optionally runs a periodic defrost cycle.
//
// Ports:
//   clk     : clock
//   rst_n   : asynchronous active-low reset
//   cool_io : fridge_cooling_ctrl_if.slave (power, setpoints, measurements, door in;
//             compressor, damper, fan, heater, state out)
//
// Configuration macro: FRIDGE_DEFROST_EN
//   defined     - run accumulator, DEFROST state and heater are built
//   not defined - no accumulator, defrost never due, heater tied low
module fridge_cooling_ctrl #(
  parameter int unsigned HYST           = 2,
  parameter int unsigned MIN_ON         = 8,
  parameter int unsigned MIN_OFF        = 16,
  parameter int unsigned DEFROST_PERIOD = 1024,
  parameter int unsigned DEFROST_LEN    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fridge_cooling_ctrl_if.slave  cool_io
);

  typedef enum logic [2:0] {
    StOff     = 3'd0,
    StIdle    = 3'd1,
    StCool    = 3'd2,
    StHold    = 3'd3,
    StDefrost = 3'd4
  } state_e;

  // The state timer only has to count up to the longest fixed duration.
  localparam int unsigned OnOffMax = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
  localparam int unsigned TmrMax   = (OnOffMax > DEFROST_LEN) ? OnOffMax : DEFROST_LEN;
  localparam int unsigned TmrW     = $clog2(TmrMax + 1);

  localparam logic [TmrW-1:0] TmrSat    = TmrW'(TmrMax);
  localparam logic [TmrW-1:0] MinOnLast = TmrW'(MIN_ON - 1);
  localparam logic [TmrW-1:0] MinOffEnd = TmrW'(MIN_OFF - 1);
  localparam logic [TmrW-1:0] DefLenEnd = TmrW'(DEFROST_LEN - 1);
  localparam logic [5:0]      HystW     = 6'(HYST);

  state_e          state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            fg_dem_q, fg_dem_d;
  logic            fr_dem_q, fr_dem_d;
  logic            defrost_due;
  logic            demand;

  // ---------------------------------------------------------------------------
  // Demand flags with hysteresis. The 6-bit threshold cannot wrap, so a
  // setpoint near the top of the range simply never raises demand.
  // ---------------------------------------------------------------------------
  logic [5:0] fg_thr, fr_thr;
  logic       fg_set, fg_clr, fr_set, fr_clr;

  assign fg_thr = {1'b0, cool_io.fgt} + HystW;
  assign fr_thr = {1'b0, cool_io.frt} + HystW;
  assign fg_set = {1'b0, cool_io.fg_meas} > fg_thr;
  assign fr_set = {1'b0, cool_io.fr_meas} > fr_thr;
  assign fg_clr = cool_io.fg_meas <= cool_io.fgt;
  assign fr_clr = cool_io.fr_meas <= cool_io.frt;

  always_comb begin
    fg_dem_d = fg_dem_q;
    fr_dem_d = fr_dem_q;
    if (!cool_io.i) begin
      fg_dem_d = 1'b0;
      fr_dem_d = 1'b0;
    end else begin
      if (fg_set) begin
        fg_dem_d = 1'b1;
      end else if (fg_clr) begin
        fg_dem_d = 1'b0;
      end
      if (fr_set) begin
        fr_dem_d = 1'b1;
      end else if (fr_clr) begin
        fr_dem_d = 1'b0;
      end
    end
  end

  assign demand = fg_dem_q | fr_dem_q;

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (!cool_io.i) begin
      // Power loss overrides every timer, including minimum on-time.
      state_d = StOff;
    end else begin
      unique case (state_q)
        StOff: begin
          // Always pass through HOLD so the compressor gets its off-time on power-up.
          state_d = StHold;
        end
        StIdle: begin
          if (defrost_due) begin
            state_d = StDefrost;
          end else if (demand) begin
            state_d = StCool;
          end
        end
        StCool: begin
          if ((tmr_q >= MinOnLast) && (defrost_due || !demand)) begin
            state_d = defrost_due ? StDefrost : StHold;
          end
        end
        StHold: begin
          if (tmr_q == MinOffEnd) begin
            state_d = StIdle;
          end
        end
        StDefrost: begin
          if (tmr_q == DefLenEnd) begin
            state_d = StHold;
          end
        end
        default: state_d = StOff;
      endcase
    end
  end

  // Timer restarts on every state change and saturates so COOL can linger indefinitely.
  always_comb begin
    tmr_d = tmr_q;
    if (state_d != state_q) begin
      tmr_d = '0;
    end else if (tmr_q != TmrSat) begin
      tmr_d = tmr_q + TmrW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StOff;
      tmr_q    <= '0;
      fg_dem_q <= 1'b0;
      fr_dem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      fg_dem_q <= fg_dem_d;
      fr_dem_q <= fr_dem_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Defrost run accumulator
  // ---------------------------------------------------------------------------
`ifdef FRIDGE_DEFROST_EN
  localparam int unsigned     AccW   = $clog2(DEFROST_PERIOD + 1);
  localparam logic [AccW-1:0] AccTop = AccW'(DEFROST_PERIOD);

  logic [AccW-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if ((state_q == StOff) || ((state_d == StDefrost) && (state_q != StDefrost))) begin
      acc_d = '0;
    end else if ((state_q == StCool) && (acc_q != AccTop)) begin
      acc_d = acc_q + AccW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign defrost_due    = (acc_q == AccTop);
  assign cool_io.heater = (state_q == StDefrost);
`else
  logic unused_defrost_period;
  assign unused_defrost_period = ^DEFROST_PERIOD;
  assign defrost_due           = 1'b0;
  assign cool_io.heater        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs (Moore, except fan which gates on the live door input)
  // ---------------------------------------------------------------------------
  assign cool_io.compressor = (state_q == StCool);
  assign cool_io.damper     = (state_q == StCool) & fg_dem_q;
  assign cool_io.fan        = (state_q == StCool) & ~cool_io.door_open;
  assign cool_io.state      = state_q;

endmodule
